// File: rtl/frame_arbiter.sv
// Arbitrates one single-port frame RAM between painter reads (priority) and buffered
// capture writes, with a starvation guard that forces a write slot when the FIFO stays full.
module frame_arbiter #(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 64
) (
  input  logic              clk50,
  input  logic              rst_n,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_grant,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [7:0]        starve_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {ARB_NORMAL, ARB_FORCE} arb_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

  wr_entry_t         fifo_q [FIFO_DEPTH];
  wr_entry_t         fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [7:0]        starve_cnt_q, starve_cnt_d;
  logic              wr_ready_q, wr_ready_d;
  logic              rd_valid_q;
  arb_state_e        state_q, state_d;

  logic      fifo_empty, fifo_full, push, rd_slot, wr_slot;
  wr_entry_t head;

  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    push       = wr_valid & wr_ready_q;
    head       = fifo_q[rd_ptr_q];
    rd_slot    = (state_q == ARB_NORMAL) & rd_req;
    // No RAM write while reset is asserted: queued entries are being discarded.
    wr_slot    = rst_n & ~fifo_empty & ((state_q == ARB_FORCE) | ~rd_req);

    rd_grant  = rd_slot;
    ram_we    = wr_slot;
    ram_addr  = rd_slot ? rd_addr : (wr_slot ? head.addr : '0);
    ram_wdata = wr_slot ? head.data : '0;

    fifo_d = fifo_q;
    if (push) fifo_d[wr_ptr_q] = '{addr: wr_addr, data: wr_data};
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(wr_slot);
    count_d    = count_q + CNT_W'(push) - CNT_W'(wr_slot);
    wr_ready_d = (count_d < CNT_W'(FIFO_DEPTH));

    state_d      = ARB_NORMAL;
    tmr_d        = '0;
    starve_cnt_d = starve_cnt_q;
    if (state_q == ARB_FORCE) begin
      if (starve_cnt_q != 8'hFF) starve_cnt_d = starve_cnt_q + 8'd1;
    end else if (fifo_full && rd_req) begin
      // Timer value k means k earlier blocked cycles; force after STARVE_LIMIT of them.
      if (tmr_q == TMR_W'(STARVE_LIMIT - 1)) state_d = ARB_FORCE;
      else                                   tmr_d   = tmr_q + TMR_W'(1);
    end
  end

  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      tmr_q        <= '0;
      starve_cnt_q <= '0;
      wr_ready_q   <= 1'b0;
      rd_valid_q   <= 1'b0;
      state_q      <= ARB_NORMAL;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      tmr_q        <= tmr_d;
      starve_cnt_q <= starve_cnt_d;
      wr_ready_q   <= wr_ready_d;
      rd_valid_q   <= rd_grant;
      state_q      <= state_d;
    end
    fifo_q <= fifo_d;
  end

  assign wr_ready   = wr_ready_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_valid_q ? ram_rdata : '0;
  assign starve_cnt = starve_cnt_q;

endmodule

// File: tb/tb_frame_arbiter.sv
// Scoreboard bench for frame_arbiter: stimulus queues expected read returns and RAM
// writes; a negedge monitor pops and compares whenever rd_valid or ram_we is seen.
module tb_frame_arbiter;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 8;

  logic clk50 = 1'b0;
  always #5 clk50 = ~clk50;

  logic              rst_n, rd_req, rd_grant, rd_valid, wr_valid, wr_ready, ram_we;
  logic [ADDR_W-1:0] rd_addr, wr_addr, ram_addr;
  logic [DATA_W-1:0] rd_data, wr_data, ram_wdata, ram_rdata;
  logic [7:0]        starve_cnt;

  frame_arbiter dut (
    .clk50(clk50), .rst_n(rst_n),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(rd_grant),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .starve_cnt(starve_cnt)
  );

  // Frame RAM: synchronous read, one cycle latency. Initial contents = addr[7:0] ^ 8'h5A.
  logic [DATA_W-1:0] mem [0:2**ADDR_W-1];
  always @(posedge clk50) begin
    if (ram_we === 1'b1) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int vectors = 0;
  int miscompares = 0;
  logic [DATA_W-1:0]        exp_rd [$];
  logic [ADDR_W+DATA_W-1:0] exp_wr [$];
  bit                       mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [DATA_W-1:0]        m_rd;
  logic [ADDR_W+DATA_W-1:0] m_wr;
  always @(negedge clk50) begin
    if (mon_en) begin
      if (rd_valid === 1'b1) begin
        if (exp_rd.size() == 0) chk("unexpected_rd_valid", 1, 0);
        else begin
          m_rd = exp_rd.pop_front();
          chk("rd_data", {24'd0, rd_data}, {24'd0, m_rd});
        end
      end else if (rd_valid !== 1'b0) chk("rd_valid_x", {31'd0, rd_valid}, 0);
      if (ram_we === 1'b1) begin
        if (exp_wr.size() == 0) chk("unexpected_ram_we", 1, 0);
        else begin
          m_wr = exp_wr.pop_front();
          chk("ram_write", {9'd0, ram_addr, ram_wdata}, {9'd0, m_wr});
        end
      end else if (ram_we !== 1'b0) chk("ram_we_x", {31'd0, ram_we}, 0);
    end
  end

  task automatic step();
    @(posedge clk50); #1;
  endtask
  task automatic at_neg();
    @(negedge clk50);
  endtask

  // Fill/starve vectors.
  logic [ADDR_W-1:0] t4_addr [4] = '{15'h0100, 15'h0101, 15'h0102, 15'h0103};
  logic [DATA_W-1:0] t4_data [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [ADDR_W-1:0] t5_addr [4] = '{15'h0200, 15'h0201, 15'h0202, 15'h0203};
  logic [DATA_W-1:0] t5_data [4] = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
  logic [ADDR_W-1:0] t6_addr [3] = '{15'h0300, 15'h0301, 15'h0302};
  logic [DATA_W-1:0] t6_data [3] = '{8'hC0, 8'hC1, 8'hC2};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rd_req = 1'b0; rd_addr = '0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < 2**ADDR_W; i++) mem[i] = i[7:0] ^ 8'h5A;
    mem[15'h1234] = 8'h55;

    // Reset held for three edges
    repeat (3) @(posedge clk50);
    #1; at_neg();
    chk("rst_rd_valid", {31'd0, rd_valid}, 0);
    chk("rst_wr_ready", {31'd0, wr_ready}, 0);
    chk("rst_ram_we", {31'd0, ram_we}, 0);
    chk("rst_starve_cnt", {24'd0, starve_cnt}, 0);
    chk("rst_ram_addr", {17'd0, ram_addr}, 0);
    mon_en = 1'b1;
    step(); rst_n = 1'b1;
    at_neg(); chk("release_wr_ready_lo", {31'd0, wr_ready}, 0);
    step(); at_neg(); chk("release_wr_ready_hi", {31'd0, wr_ready}, 1);

    // Read only
    step(); rd_req = 1'b1; rd_addr = 15'h1234; exp_rd.push_back(8'h55);
    at_neg();
    chk("rd_grant", {31'd0, rd_grant}, 1);
    chk("rd_ram_addr", {17'd0, ram_addr}, 32'h1234);
    chk("rd_ram_we", {31'd0, ram_we}, 0);
    step(); rd_req = 1'b0;
    at_neg(); chk("rd_valid_next", {31'd0, rd_valid}, 1);

    // Write only: one cycle from accept to RAM write
    step(); wr_valid = 1'b1; wr_addr = 15'h0010; wr_data = 8'hA5; exp_wr.push_back({15'h0010, 8'hA5});
    at_neg(); chk("wr_no_bypass", {31'd0, ram_we}, 0);
    step(); wr_valid = 1'b0;
    at_neg();
    chk("wr_ram_we", {31'd0, ram_we}, 1);
    chk("wr_ram_addr", {17'd0, ram_addr}, 32'h0010);
    chk("wr_ram_wdata", {24'd0, ram_wdata}, 32'hA5);
    step(); at_neg(); chk("wr_fifo_empty", {31'd0, ram_we}, 0);
    step(); rd_req = 1'b1; rd_addr = 15'h0010; exp_rd.push_back(8'hA5);
    at_neg();
    step(); rd_req = 1'b0;

    // Collision: read of an address still queued returns old contents
    rd_req = 1'b1; rd_addr = 15'h0400; wr_valid = 1'b1; wr_addr = 15'h0400; wr_data = 8'hEE;
    exp_rd.push_back(8'h5A); exp_wr.push_back({15'h0400, 8'hEE});
    at_neg(); chk("col_no_we", {31'd0, ram_we}, 0);
    step(); wr_valid = 1'b0; exp_rd.push_back(8'h5A);
    at_neg(); chk("col_read_wins", {30'd0, rd_grant, ram_we}, 32'b10);
    step(); rd_req = 1'b0;
    at_neg(); chk("col_drain", {31'd0, ram_we}, 1);
    step(); rd_req = 1'b1; exp_rd.push_back(8'hEE);
    at_neg();
    step(); rd_req = 1'b0;

    // Priority / full: reads block writes, then drain in order
    for (int i = 0; i < 4; i++) begin
      rd_req = 1'b1; rd_addr = 15'h0077; wr_valid = 1'b1; wr_addr = t4_addr[i]; wr_data = t4_data[i];
      exp_rd.push_back(8'h2D); exp_wr.push_back({t4_addr[i], t4_data[i]});
      at_neg();
      chk("full_fill_we", {31'd0, ram_we}, 0);
      chk("full_fill_ready", {31'd0, wr_ready}, 1);
      step();
    end
    wr_valid = 1'b0; exp_rd.push_back(8'h2D);
    at_neg();
    chk("full_wr_ready", {31'd0, wr_ready}, 0);
    chk("full_no_we", {31'd0, ram_we}, 0);
    step(); rd_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      at_neg(); chk("drain_we", {31'd0, ram_we}, 1);
      step();
    end
    at_neg(); chk("drain_done", {31'd0, ram_we}, 0);
    step();

    // Starvation: 64 full+blocked cycles, then one forced write
    for (int i = 0; i < 4; i++) begin
      rd_req = 1'b1; rd_addr = 15'h0077; wr_valid = 1'b1; wr_addr = t5_addr[i]; wr_data = t5_data[i];
      exp_rd.push_back(8'h2D); exp_wr.push_back({t5_addr[i], t5_data[i]});
      at_neg(); step();
    end
    wr_valid = 1'b0;
    for (int c = 0; c < 64; c++) begin
      exp_rd.push_back(8'h2D);
      at_neg(); chk("starve_blocked", {30'd0, rd_grant, ram_we}, 32'b10);
      step();
    end
    at_neg();
    chk("force_slot", {30'd0, rd_grant, ram_we}, 32'b01);
    chk("force_addr", {17'd0, ram_addr}, 32'h0200);
    chk("force_cnt_before", {24'd0, starve_cnt}, 0);
    step(); exp_rd.push_back(8'h2D);
    at_neg();
    chk("force_cnt_after", {24'd0, starve_cnt}, 1);
    chk("force_wr_ready", {31'd0, wr_ready}, 1);
    chk("force_back_normal", {31'd0, rd_grant}, 1);
    step(); rd_req = 1'b0;
    repeat (3) begin at_neg(); step(); end
    at_neg(); chk("starve_drain_done", {31'd0, ram_we}, 0);
    step();

    // Mid-operation reset discards queued writes
    for (int i = 0; i < 3; i++) begin
      rd_req = 1'b1; rd_addr = 15'h0077; wr_valid = 1'b1; wr_addr = t6_addr[i]; wr_data = t6_data[i];
      exp_rd.push_back(8'h2D);
      at_neg(); chk("mid_fill_we", {31'd0, ram_we}, 0);
      step();
    end
    wr_valid = 1'b0; rst_n = 1'b0;
    at_neg(); chk("mid_rst_we", {31'd0, ram_we}, 0);
    step(); rst_n = 1'b1; rd_req = 1'b0;
    at_neg();
    chk("mid_rst_no_rd_valid", {31'd0, rd_valid}, 0);
    chk("mid_rst_wr_ready", {31'd0, wr_ready}, 0);
    chk("mid_rst_starve_cnt", {24'd0, starve_cnt}, 0);
    for (int i = 0; i < 4; i++) begin
      step(); at_neg();
      chk("mid_rst_no_we", {31'd0, ram_we}, 0);
      chk("mid_rst_ready", {31'd0, wr_ready}, 1);
    end

    chk("exp_rd_drained", exp_rd.size(), 0);
    chk("exp_wr_drained", exp_wr.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
